// File: rtl/systolic_drain.sv
// Output-side reader for an output-stationary systolic array: scans one column of
// MAC_out per cycle into a small column FIFO and streams the beats out with valid/ready.
module systolic_drain #(
   parameter int WIDTH_MAC = 48,
   parameter int x_axis    = 3,
   parameter int y_axis    = 3,
   parameter int DEPTH     = 4,
   localparam int COL_W    = (x_axis > 1) ? $clog2(x_axis) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [WIDTH_MAC*y_axis-1:0] mac_col,
   output logic                        cscan_en,
   output logic [WIDTH_MAC*y_axis-1:0] out_data,
   output logic [COL_W-1:0]            out_col,
   output logic                        out_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy,
   output logic                        done
);

   localparam int DW    = WIDTH_MAC * y_axis;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(x_axis - 1);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

   state_t           state_q, state_d;
   logic [COL_W-1:0] scan_q, scan_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [DW-1:0]    data_mem [DEPTH];
   logic [COL_W-1:0] col_mem  [DEPTH];
   logic             push, pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         scan_q  <= '0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         scan_q  <= scan_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end

   // FIFO storage carries no reset; the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_q] <= mac_col;
         col_mem[wr_q]  <= scan_q;
      end
   end

   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      count_d   = count_q;
      wr_d      = wr_q;
      rd_d      = rd_q;
      cscan_en  = 1'b0;
      done      = 1'b0;
      push      = 1'b0;
      busy      = (state_q != IDLE);
      out_valid = (count_q != '0);
      out_data  = '0;
      out_col   = '0;
      out_last  = 1'b0;
      if (out_valid) begin
         out_data = data_mem[rd_q];
         out_col  = col_mem[rd_q];
         out_last = (col_mem[rd_q] == LAST_COL);
      end
      pop = out_valid & out_ready;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               scan_d  = '0;
            end
         end
         SCAN: begin
            // The array only shifts when the FIFO can take the column it exposes.
            cscan_en = (count_q < FULL);
            push     = cscan_en;
            if (push) begin
               if (scan_q == LAST_COL) state_d = FLUSH;
               else                    scan_d  = scan_q + 1'b1;
            end
         end
         FLUSH: begin
            if (pop && out_last) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

endmodule

// File: tb/tb_systolic_drain.sv
// Bench for systolic_drain: three instances (basic, shallow FIFO, long array) driven by
// directed sequences; a queue-based scoreboard checks every accepted beat.
module tb_systolic_drain;

   localparam int W  = 48;
   localparam int DW = 3 * W;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
      bit            l;
   } beat_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          st0, rdy0, cs0, ol0, ov0, by0, dn0;
   logic          st1, rdy1, cs1, ol1, ov1, by1, dn1;
   logic          st2, rdy2, cs2, ol2, ov2, by2, dn2;
   logic [DW-1:0] mc0, od0, mc1, od1, mc2, od2;
   logic [1:0]    oc0, oc1;
   logic [2:0]    oc2;
   int            base0, base1, base2;
   int            sh0, sh1, sh2;

   int nchk  = 0;
   int nfail = 0;
   int dn_cnt0 = 0, dn_cnt1 = 0, dn_cnt2 = 0;
   int cs_cnt0 = 0, cs_cnt1 = 0, cs_cnt2 = 0;
   beat_t q0[$], q1[$], q2[$];
   beat_t b0, b1, b2;
   logic       pp_prev = 1'b0;
   logic [2:0] pp_cnt;

   systolic_drain #(.WIDTH_MAC(W), .x_axis(3), .y_axis(3), .DEPTH(4)) u0 (
      .clk(clk), .rst(rst), .start(st0), .mac_col(mc0), .cscan_en(cs0), .out_data(od0),
      .out_col(oc0), .out_last(ol0), .out_valid(ov0), .out_ready(rdy0), .busy(by0), .done(dn0));
   systolic_drain #(.WIDTH_MAC(W), .x_axis(3), .y_axis(3), .DEPTH(2)) u1 (
      .clk(clk), .rst(rst), .start(st1), .mac_col(mc1), .cscan_en(cs1), .out_data(od1),
      .out_col(oc1), .out_last(ol1), .out_valid(ov1), .out_ready(rdy1), .busy(by1), .done(dn1));
   systolic_drain #(.WIDTH_MAC(W), .x_axis(8), .y_axis(3), .DEPTH(4)) u2 (
      .clk(clk), .rst(rst), .start(st2), .mac_col(mc2), .cscan_en(cs2), .out_data(od2),
      .out_col(oc2), .out_last(ol2), .out_valid(ov2), .out_ready(rdy2), .busy(by2), .done(dn2));

   // Column c of a drain, row y = base + 3c + y + 1 (base 0, col 0 gives {3,2,1}).
   function automatic logic [DW-1:0] col_word(input int base, input int c);
      logic [DW-1:0] w;
      for (int y = 0; y < 3; y++) w[y*W +: W] = W'(base + 3 * c + y + 1);
      return w;
   endfunction

   // Array model: exposes column k after k shifts; reloaded by an accepted start.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sh0 <= 0; sh1 <= 0; sh2 <= 0;
      end else begin
         if (st0 && !by0) sh0 <= 0; else if (cs0) sh0 <= sh0 + 1;
         if (st1 && !by1) sh1 <= 0; else if (cs1) sh1 <= sh1 + 1;
         if (st2 && !by2) sh2 <= 0; else if (cs2) sh2 <= sh2 + 1;
      end
   end
   assign mc0 = col_word(base0, sh0);
   assign mc1 = col_word(base1, sh1);
   assign mc2 = col_word(base2, sh2);

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
      nchk++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic exp_drain(input int inst, input int base, input int nx);
      beat_t b;
      for (int c = 0; c < nx; c++) begin
         b.d = col_word(base, c);
         b.c = c;
         b.l = (c == nx - 1);
         case (inst)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            default: q2.push_back(b);
         endcase
      end
   endtask

   // Scoreboard monitors: a beat is taken when valid & ready are seen mid-cycle.
   always @(negedge clk) begin
      if (!rst && ov0 && rdy0) begin
         if (q0.size() == 0) chk("u0_unexpected_beat", 1, 0);
         else begin
            b0 = q0.pop_front();
            chk("u0_data", od0, b0.d);
            chk("u0_col_last", {oc0, ol0}, {b0.c[1:0], b0.l});
         end
      end
      if (dn0) dn_cnt0++;
      if (cs0) cs_cnt0++;
   end

   always @(negedge clk) begin
      if (!rst && ov1 && rdy1) begin
         if (q1.size() == 0) chk("u1_unexpected_beat", 1, 0);
         else begin
            b1 = q1.pop_front();
            chk("u1_data", od1, b1.d);
            chk("u1_col_last", {oc1, ol1}, {b1.c[1:0], b1.l});
         end
      end
      if (dn1) dn_cnt1++;
      if (cs1) cs_cnt1++;
   end

   always @(negedge clk) begin
      if (!rst && ov2 && rdy2) begin
         if (q2.size() == 0) chk("u2_unexpected_beat", 1, 0);
         else begin
            b2 = q2.pop_front();
            chk("u2_data", od2, b2.d);
            chk("u2_col_last", {oc2, ol2}, {b2.c[2:0], b2.l});
         end
      end
      if (pp_prev) chk("u2_pushpop_count", u2.count_q, pp_cnt);
      pp_prev = !rst && cs2 && ov2 && rdy2;
      pp_cnt  = u2.count_q;
      if (dn2) dn_cnt2++;
      if (cs2) cs_cnt2++;
   end

   // Drives u0's start from a per-cycle pattern and records its control outputs.
   task automatic trace0(input int n, input logic [31:0] stpat,
                         output logic [31:0] cs, output logic [31:0] ov,
                         output logic [31:0] by, output logic [31:0] dn);
      cs = '0; ov = '0; by = '0; dn = '0;
      st0 = stpat[0];
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         cs[k] = cs0; ov[k] = ov0; by[k] = by0; dn[k] = dn0;
         @(posedge clk); #1;
         st0 = stpat[k+1];
      end
   endtask

   initial begin
      logic [31:0] cs, ov, by, dn;
      int snap;
      rst = 1'b1;
      st0 = 0; st1 = 0; st2 = 0;
      rdy0 = 0; rdy1 = 0; rdy2 = 0;
      base0 = 0; base1 = 0; base2 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_u0", {cs0, ov0, ol0, by0, dn0, od0, oc0}, '0);
      chk("reset_outputs_u2", {cs2, ov2, ol2, by2, dn2, od2, oc2}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic drain with out_ready held high
      rdy0 = 1; base0 = 0;
      exp_drain(0, 0, 3);
      snap = dn_cnt0;
      trace0(7, 32'b1, cs, ov, by, dn);
      chk("basic_cscan", cs, 32'b0001110);
      chk("basic_valid", ov, 32'b0011100);
      chk("basic_busy", by, 32'b0111110);
      chk("basic_done", dn, 32'b0100000);
      chk("basic_queue_empty", q0.size(), 0);
      chk("basic_done_count", dn_cnt0 - snap, 1);

      // start during SCAN and during DONE must be ignored
      base0 = 100;
      exp_drain(0, 100, 3);
      snap = dn_cnt0;
      trace0(9, 32'b100011, cs, ov, by, dn);
      chk("ign_cscan", cs, 32'b000001110);
      chk("ign_done", dn, 32'b000100000);
      chk("ign_done_count", dn_cnt0 - snap, 1);
      chk("ign_queue_empty", q0.size(), 0);

      // Asynchronous reset after one push with out_ready low
      rdy0 = 0; base0 = 200;
      trace0(2, 32'b1, cs, ov, by, dn);
      chk("rst_pre_state", {ov0, by0, oc0}, {1'b1, 1'b1, 2'd0});
      #2 rst = 1'b1;
      #1 chk("rst_async_outputs", {cs0, ov0, ol0, by0, dn0, od0, oc0}, '0);
      snap = dn_cnt0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      chk("rst_no_done", dn_cnt0 - snap, 0);
      rdy0 = 1; base0 = 300;
      exp_drain(0, 300, 3);
      trace0(7, 32'b1, cs, ov, by, dn);
      chk("post_rst_cscan", cs, 32'b0001110);
      chk("post_rst_done", dn, 32'b0100000);

      // Back-to-back drains; FIFO pointers wrap across them
      base0 = 400;
      exp_drain(0, 400, 3);
      trace0(6, 32'b1, cs, ov, by, dn);
      chk("b2b_first_done", dn, 32'b100000);
      base0 = 500;
      exp_drain(0, 500, 3);
      trace0(7, 32'b1, cs, ov, by, dn);
      chk("b2b_second_cscan", cs, 32'b0001110);
      chk("b2b_second_done", dn, 32'b0100000);
      chk("b2b_queue_empty", q0.size(), 0);

      // Backpressure on the DEPTH=2 instance
      rdy1 = 0; base1 = 1000;
      exp_drain(1, 1000, 3);
      cs = '0;
      st1 = 1;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); cs[k] = cs1;
         @(posedge clk); #1; st1 = 0;
      end
      chk("bp_cscan_stall", cs, 32'b0000110);
      chk("bp_count_full", u1.count_q, 2);
      chk("bp_head_hold", {ov1, od1, oc1}, {1'b1, col_word(1000, 0), 2'd0});
      rdy1 = 1;
      cs = '0; dn = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); cs[k] = cs1; dn[k] = dn1;
         @(posedge clk); #1;
      end
      chk("bp_cscan_resume", cs, 32'b000010);
      chk("bp_done", dn, 32'b001000);
      chk("bp_queue_empty", q1.size(), 0);
      chk("bp_cscan_total", cs_cnt1, 3);
      chk("bp_done_count", dn_cnt1, 1);

      // Toggling out_ready on the x_axis=8 instance
      base2 = 2000;
      exp_drain(2, 2000, 8);
      rdy2 = 1; st2 = 1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         st2 = 0;
         rdy2 = ~rdy2;
      end
      chk("tog_queue_empty", q2.size(), 0);
      chk("tog_cscan_total", cs_cnt2, 8);
      chk("tog_done_count", dn_cnt2, 1);
      chk("tog_idle", {by2, ov2}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
